// File: rtl/fetch_stage_pkg.sv
// Shared widths, reset/bubble defaults and the fetch FSM encoding.
package fetch_stage_pkg;

  localparam int unsigned INST_LEN = 32;
  localparam int unsigned ARCH_LEN = 32;

  localparam logic [INST_LEN-1:0] DEFAULT_NOP_INST = 32'h0000_0013;
  localparam logic [ARCH_LEN-1:0] DEFAULT_RESET_PC = 32'h0000_1000;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the PC, single outstanding imem request,
// one-entry output slot to decode with stall and EXE redirect handling.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [ARCH_LEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [INST_LEN-1:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_dec_in,
  input  logic                redirect_valid,
  input  logic [ARCH_LEN-1:0] redirect_pc,
  output logic                imem_req_valid,
  output logic [ARCH_LEN-1:0] imem_req_addr,
  input  logic                imem_req_ready,
  input  logic                imem_resp_valid,
  input  logic [INST_LEN-1:0] imem_resp_data,
  output logic                imem_resp_ready,
  output logic [INST_LEN-1:0] inst_fetched_out,
  output logic                inst_valid_out,
  output logic [ARCH_LEN-1:0] pc_out
);

  fetch_state_t        state_q, state_d;
  logic [ARCH_LEN-1:0] pc_q, pc_d;
  logic [INST_LEN-1:0] inst_q, inst_d;
  logic [ARCH_LEN-1:0] slot_pc_q, slot_pc_d;
  logic                valid_q, valid_d;

  logic                slot_free;
  logic                accept;
  logic [ARCH_LEN-1:0] redirect_tgt;

  assign redirect_tgt = redirect_pc & ~ARCH_LEN'(3);
  assign slot_free    = ~valid_q | ~stall_dec_in;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    inst_d          = inst_q;
    slot_pc_d       = slot_pc_q;
    valid_d         = valid_q;
    accept          = 1'b0;
    imem_req_valid  = 1'b0;
    imem_resp_ready = 1'b0;

    case (state_q)
      REQ: begin
        imem_req_valid = ~redirect_valid;
        if (redirect_valid) begin
          pc_d = redirect_tgt;
        end else if (imem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        imem_resp_ready = slot_free | redirect_valid;
        if (redirect_valid) begin
          // A response arriving with the redirect is consumed and dropped here;
          // otherwise it is still in flight and must be drained later.
          pc_d    = redirect_tgt;
          state_d = imem_resp_valid ? REQ : DRAIN;
        end else if (imem_resp_valid && slot_free) begin
          accept  = 1'b1;
          pc_d    = pc_q + ARCH_LEN'(4);
          state_d = REQ;
        end
      end
      DRAIN: begin
        imem_resp_ready = 1'b1;
        if (redirect_valid) pc_d = redirect_tgt;
        if (imem_resp_valid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase

    if (redirect_valid) begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
    end else if (accept) begin
      valid_d   = 1'b1;
      inst_d    = imem_resp_data;
      slot_pc_d = pc_q;
    end else if (valid_q && !stall_dec_in) begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
    end

    if (rst) begin
      imem_req_valid  = 1'b0;
      imem_resp_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= REQ;
      pc_q      <= RESET_PC;
      inst_q    <= NOP_INST;
      slot_pc_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      slot_pc_q <= slot_pc_d;
      valid_q   <= valid_d;
    end
  end

  assign imem_req_addr    = pc_q;
  assign inst_fetched_out = inst_q;
  assign inst_valid_out   = valid_q;
  assign pc_out           = slot_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a single-outstanding imem model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_dec_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_ready;
  logic [31:0] inst_fetched_out;
  logic        inst_valid_out;
  logic [31:0] pc_out;

  int unsigned passed = 0;
  int unsigned total  = 0;

  // Memory model: one pending request, response after mem_delay extra cycles,
  // held until accepted.
  int unsigned mem_delay;
  logic        pend_q;
  logic [31:0] addr_q;
  int unsigned cnt_q;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC(32'h0000_1000),
    .NOP_INST(32'h0000_0013)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_dec_in     (stall_dec_in),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_req_valid   (imem_req_valid),
    .imem_req_addr    (imem_req_addr),
    .imem_req_ready   (imem_req_ready),
    .imem_resp_valid  (imem_resp_valid),
    .imem_resp_data   (imem_resp_data),
    .imem_resp_ready  (imem_resp_ready),
    .inst_fetched_out (inst_fetched_out),
    .inst_valid_out   (inst_valid_out),
    .pc_out           (pc_out)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_1000: mem_word = 32'h00A0_0093;
      32'h0000_1004: mem_word = 32'h0010_0113;
      default:       mem_word = a ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  assign imem_resp_valid = pend_q && (cnt_q == 0);
  assign imem_resp_data  = imem_resp_valid ? mem_word(addr_q) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (rst) begin
      pend_q <= 1'b0;
      cnt_q  <= 0;
      addr_q <= '0;
    end else if (pend_q) begin
      if (cnt_q != 0) cnt_q <= cnt_q - 1;
      else if (imem_resp_ready) pend_q <= 1'b0;
    end else if (imem_req_valid && imem_req_ready) begin
      pend_q <= 1'b1;
      addr_q <= imem_req_addr;
      cnt_q  <= mem_delay;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; stall_dec_in = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; mem_delay = 0;

    // Reset
    tick();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_resp_ready", 32'(imem_resp_ready), 32'd0);
    tick();
    chk("rst_inst_valid", 32'(inst_valid_out), 32'd0);
    chk("rst_inst", inst_fetched_out, 32'h0000_0013);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_req_valid2", 32'(imem_req_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("post_rst_addr", imem_req_addr, 32'h0000_1000);
    chk("post_rst_inst_valid", 32'(inst_valid_out), 32'd0);
    chk("post_rst_inst", inst_fetched_out, 32'h0000_0013);

    // Zero-wait stream
    tick();
    chk("wait_req_valid", 32'(imem_req_valid), 32'd0);
    chk("wait_resp_ready", 32'(imem_resp_ready), 32'd1);
    tick();
    chk("s0_valid", 32'(inst_valid_out), 32'd1);
    chk("s0_inst", inst_fetched_out, 32'h00A0_0093);
    chk("s0_pc", pc_out, 32'h0000_1000);
    chk("s0_next_addr", imem_req_addr, 32'h0000_1004);
    tick();
    chk("gap_valid", 32'(inst_valid_out), 32'd0);
    chk("gap_inst", inst_fetched_out, 32'h0000_0013);
    tick();
    chk("s1_valid", 32'(inst_valid_out), 32'd1);
    chk("s1_inst", inst_fetched_out, 32'h0010_0113);
    chk("s1_pc", pc_out, 32'h0000_1004);
    chk("s1_next_addr", imem_req_addr, 32'h0000_1008);

    // Stall three cycles with the next response pending
    stall_dec_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_resp_ready", 32'(imem_resp_ready), 32'd0);
      chk("stall_valid", 32'(inst_valid_out), 32'd1);
      chk("stall_inst", inst_fetched_out, 32'h0010_0113);
      chk("stall_pc", pc_out, 32'h0000_1004);
    end
    stall_dec_in = 1'b0;
    #1;
    chk("unstall_resp_ready", 32'(imem_resp_ready), 32'd1);
    tick();
    chk("s2_valid", 32'(inst_valid_out), 32'd1);
    chk("s2_inst", inst_fetched_out, 32'h5A5A_4A52);
    chk("s2_pc", pc_out, 32'h0000_1008);
    chk("s2_next_addr", imem_req_addr, 32'h0000_100C);

    // Redirect in WAIT, late response drained
    mem_delay = 3;
    tick();
    chk("w_resp_valid", 32'(imem_resp_valid), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2002;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("drain_valid", 32'(inst_valid_out), 32'd0);
    chk("drain_req_valid", 32'(imem_req_valid), 32'd0);
    chk("drain_resp_ready", 32'(imem_resp_ready), 32'd1);
    chk("drain_addr", imem_req_addr, 32'h0000_2000);
    tick();
    chk("drain_req_valid2", 32'(imem_req_valid), 32'd0);
    tick();
    chk("drain_req_valid3", 32'(imem_req_valid), 32'd0);
    tick();
    chk("after_drain_valid", 32'(inst_valid_out), 32'd0);
    chk("after_drain_inst", inst_fetched_out, 32'h0000_0013);
    chk("after_drain_req_valid", 32'(imem_req_valid), 32'd1);
    chk("after_drain_addr", imem_req_addr, 32'h0000_2000);
    mem_delay = 0;

    // Redirect together with resp_valid
    tick();
    chk("coinc_resp_valid", 32'(imem_resp_valid), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3000;
    #1;
    chk("coinc_resp_ready", 32'(imem_resp_ready), 32'd1);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("coinc_valid", 32'(inst_valid_out), 32'd0);
    chk("coinc_no_drain", 32'(imem_req_valid), 32'd1);
    chk("coinc_addr", imem_req_addr, 32'h0000_3000);

    // Redirect in REQ with memory not ready
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_4000;
    #1;
    chk("req_redir_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("req_redir_valid_after", 32'(imem_req_valid), 32'd1);
    chk("req_redir_addr", imem_req_addr, 32'h0000_4000);
    tick();
    chk("req_hold_addr", imem_req_addr, 32'h0000_4000);

    // Wrap at the top of the address space
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    chk("wrap_valid", 32'(inst_valid_out), 32'd1);
    chk("wrap_inst", inst_fetched_out, 32'hA5A5_A5A6);
    chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
    chk("wrap_next_addr", imem_req_addr, 32'h0000_0000);

    // Reset with a response in flight
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("midrst_valid", 32'(inst_valid_out), 32'd0);
    chk("midrst_pc_out", pc_out, 32'h0);
    rst = 1'b0;
    #1;
    chk("midrst_req_valid2", 32'(imem_req_valid), 32'd1);
    chk("midrst_addr", imem_req_addr, 32'h0000_1000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
